// File: rtl/wb_gpio_irq.sv
// Wishbone classic GPIO with per-pin direction, set/clear/toggle and edge interrupts.
// Every access is acked one cycle after the strobe. Inputs take SYNC_STAGES cycles to appear in IN.
module wb_gpio_irq #(
   parameter int              WIDTH       = 8,
   parameter int              SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_OUT  = '0,
   parameter logic [WIDTH-1:0] RESET_DIR  = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [5:0]       wb_adr_i,
   input  logic [3:0]       wb_sel_i,
   input  logic [31:0]      wb_dat_i,
   output logic [31:0]      wb_dat_o,
   output logic             wb_ack_o,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_dir_o,
   output logic             irq_o
);

   localparam logic [3:0] IDX_IN      = 4'd0;
   localparam logic [3:0] IDX_OUT     = 4'd1;
   localparam logic [3:0] IDX_DIR     = 4'd2;
   localparam logic [3:0] IDX_SET     = 4'd3;
   localparam logic [3:0] IDX_CLR     = 4'd4;
   localparam logic [3:0] IDX_TGL     = 4'd5;
   localparam logic [3:0] IDX_RISE_EN = 4'd6;
   localparam logic [3:0] IDX_FALL_EN = 4'd7;
   localparam logic [3:0] IDX_STAT    = 4'd8;

   logic                              ack_q, ack_d;
   logic [31:0]                       dat_q, dat_d;
   logic [WIDTH-1:0]                  out_q, out_d;
   logic [WIDTH-1:0]                  dir_q, dir_d;
   logic [WIDTH-1:0]                  rise_en_q, rise_en_d;
   logic [WIDTH-1:0]                  fall_en_q, fall_en_d;
   logic [WIDTH-1:0]                  stat_q, stat_d;
   logic [WIDTH-1:0]                  prev_q, prev_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [1:0]                        arm_cnt_q, arm_cnt_d;
   logic                              armed_q, armed_d;
   logic                              irq_q, irq_d;

   logic             access;
   logic             wr_en;
   logic [3:0]       idx;
   logic [31:0]      sel_mask;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] wm;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] rd_w;
   logic             unused_adr;

   assign unused_adr = ^wb_adr_i[1:0];

   assign access   = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wr_en    = access & wb_we_i;
   assign idx      = wb_adr_i[5:2];
   assign sel_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign wd       = WIDTH'(wb_dat_i & sel_mask);
   assign wm       = WIDTH'(sel_mask);
   assign sync     = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d[0] = gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      prev_d = sync;
      // Pins high at reset would look like a rise once the chain fills; hold off until then.
      arm_cnt_d = armed_q ? arm_cnt_q : arm_cnt_q + 2'd1;
      armed_d   = armed_q | (arm_cnt_q == 2'(SYNC_STAGES));
      evt       = armed_q ? ((sync & ~prev_q & rise_en_q) | (~sync & prev_q & fall_en_q)) : '0;
   end

   always_comb begin
      out_d     = out_q;
      dir_d     = dir_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c       = '0;
      if (wr_en) begin
         case (idx)
            IDX_OUT:     out_d     = (out_q & ~wm) | wd;
            IDX_DIR:     dir_d     = (dir_q & ~wm) | wd;
            IDX_SET:     out_d     = out_q | wd;
            IDX_CLR:     out_d     = out_q & ~wd;
            IDX_TGL:     out_d     = out_q ^ wd;
            IDX_RISE_EN: rise_en_d = (rise_en_q & ~wm) | wd;
            IDX_FALL_EN: fall_en_d = (fall_en_q & ~wm) | wd;
            IDX_STAT:    w1c       = wd;
            default:     ;
         endcase
      end
      // A new event in the same cycle as its clear keeps the bit set.
      stat_d = (stat_q & ~w1c) | evt;
      irq_d  = |stat_q;
   end

   always_comb begin
      rd_w = '0;
      case (idx)
         IDX_IN:      rd_w = sync;
         IDX_OUT:     rd_w = out_q;
         IDX_DIR:     rd_w = dir_q;
         IDX_RISE_EN: rd_w = rise_en_q;
         IDX_FALL_EN: rd_w = fall_en_q;
         IDX_STAT:    rd_w = stat_q;
         default:     rd_w = '0;
      endcase
      ack_d = access;
      dat_d = (access & ~wb_we_i) ? 32'(rd_w) : 32'd0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ack_q     <= 1'b0;
         dat_q     <= '0;
         out_q     <= RESET_OUT;
         dir_q     <= RESET_DIR;
         rise_en_q <= '0;
         fall_en_q <= '0;
         stat_q    <= '0;
         prev_q    <= '0;
         sync_q    <= '0;
         arm_cnt_q <= '0;
         armed_q   <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         out_q     <= out_d;
         dir_q     <= dir_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         stat_q    <= stat_d;
         prev_q    <= prev_d;
         sync_q    <= sync_d;
         arm_cnt_q <= arm_cnt_d;
         armed_q   <= armed_d;
         irq_q     <= irq_d;
      end
   end

   assign wb_ack_o   = ack_q;
   assign wb_dat_o   = dat_q;
   assign gpio_o     = out_q;
   assign gpio_dir_o = dir_q;
   assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq: register vector table plus timed edge/interrupt sequences.
module tb_wb_gpio_irq;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [5:0]  wb_adr_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic [7:0]  gpio_i, gpio_o, gpio_dir_o;
   logic        irq_o;

   always #5 clock = ~clock;

   wb_gpio_irq #(
      .WIDTH(8), .SYNC_STAGES(2), .RESET_OUT(8'h05), .RESET_DIR(8'h00)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_dir_o(gpio_dir_o), .irq_o(irq_o)
   );

   typedef struct {
      logic        we;
      logic [3:0]  idx;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] exp_rd;
      logic [7:0]  exp_out;
      logic [7:0]  exp_dir;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One classic access; also checks the ack arrives after one edge and lasts one cycle.
   task automatic bus(input logic we, input logic [3:0] idx, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rd);
      int cyc_n;
      bit got;
      @(negedge clock);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = {idx, 2'b00}; wb_sel_i = sel; wb_dat_i = dat;
      got = 1'b0; cyc_n = 0;
      while (!got && cyc_n < 8) begin
         @(posedge clock); #1;
         cyc_n++;
         if (wb_ack_o) got = 1'b1;
      end
      rd = wb_dat_o;
      check("ack_latency", 32'(cyc_n), 32'd1);
      @(negedge clock);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      @(posedge clock); #1;
      check("ack_single_cycle", {31'd0, wb_ack_o}, 32'd0);
   endtask

   task automatic wr(input logic [3:0] idx, input logic [31:0] dat);
      logic [31:0] rd;
      bus(1'b1, idx, 4'hF, dat, rd);
   endtask

   task automatic read_expect(input string name, input logic [3:0] idx, input logic [31:0] exp);
      logic [31:0] rd;
      sb_t e;
      sb_q.push_back('{name, exp});
      bus(1'b0, idx, 4'hF, 32'd0, rd);
      e = sb_q.pop_front();
      check(e.name, rd, e.exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      sb_t e;

      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
      gpio_i = 8'hA5;
      reset_n = 1'b0;

      // Test 1: reset values and IN read
      repeat (3) @(posedge clock);
      #1;
      check("rst_gpio_o", 32'(gpio_o), 32'h05);
      check("rst_dir", 32'(gpio_dir_o), 32'h00);
      check("rst_irq", {31'd0, irq_o}, 32'd0);
      check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
      check("rst_dat_o", wb_dat_o, 32'd0);
      @(negedge clock); reset_n = 1'b1;
      repeat (5) @(posedge clock);
      read_expect("in_read", 4'd0, 32'h0000_00A5);

      // Register vector table (gpio_i held at A5)
      //            we    idx    sel      dat            exp_rd        out    dir
      vecs.push_back('{1'b1, 4'd1,  4'hF, 32'h0000_00F0, 32'h0,        8'hF0, 8'h00});
      vecs.push_back('{1'b1, 4'd3,  4'hF, 32'h0000_000F, 32'h0,        8'hFF, 8'h00});
      vecs.push_back('{1'b1, 4'd4,  4'hF, 32'h0000_0081, 32'h0,        8'h7E, 8'h00});
      vecs.push_back('{1'b1, 4'd5,  4'hF, 32'h0000_00FF, 32'h0,        8'h81, 8'h00});
      vecs.push_back('{1'b0, 4'd1,  4'hF, 32'h0,         32'h0000_0081, 8'h81, 8'h00});
      vecs.push_back('{1'b1, 4'd2,  4'hF, 32'h0000_003C, 32'h0,        8'h81, 8'h3C});
      vecs.push_back('{1'b0, 4'd2,  4'hF, 32'h0,         32'h0000_003C, 8'h81, 8'h3C});
      vecs.push_back('{1'b0, 4'd3,  4'hF, 32'h0,         32'h0,        8'h81, 8'h3C});
      vecs.push_back('{1'b1, 4'd12, 4'hF, 32'hFFFF_FFFF, 32'h0,        8'h81, 8'h3C});
      vecs.push_back('{1'b0, 4'd12, 4'hF, 32'h0,         32'h0,        8'h81, 8'h3C});
      vecs.push_back('{1'b1, 4'd1,  4'h1, 32'hFFFF_FFFF, 32'h0,        8'hFF, 8'h3C});
      vecs.push_back('{1'b0, 4'd1,  4'hF, 32'h0,         32'h0000_00FF, 8'hFF, 8'h3C});
      vecs.push_back('{1'b1, 4'd1,  4'h2, 32'h0000_5A00, 32'h0,        8'hFF, 8'h3C});
      vecs.push_back('{1'b1, 4'd0,  4'hF, 32'h0000_0000, 32'h0,        8'hFF, 8'h3C});
      vecs.push_back('{1'b0, 4'd0,  4'hF, 32'h0,         32'h0000_00A5, 8'hFF, 8'h3C});
      vecs.push_back('{1'b1, 4'd7,  4'hF, 32'hFFFF_FF00, 32'h0,        8'hFF, 8'h3C});
      vecs.push_back('{1'b0, 4'd7,  4'hF, 32'h0,         32'h0,        8'hFF, 8'h3C});
      vecs.push_back('{1'b0, 4'd9,  4'hF, 32'h0,         32'h0,        8'hFF, 8'h3C});
      vecs.push_back('{1'b0, 4'd8,  4'hF, 32'h0,         32'h0,        8'hFF, 8'h3C});
      vecs.push_back('{1'b1, 4'd2,  4'hF, 32'h0000_0000, 32'h0,        8'hFF, 8'h00});

      for (int i = 0; i < vecs.size(); i++) begin
         if (!vecs[i].we) sb_q.push_back('{$sformatf("vec%0d_rdata", i), vecs[i].exp_rd});
         bus(vecs[i].we, vecs[i].idx, vecs[i].sel, vecs[i].dat, rd);
         if (!vecs[i].we) begin
            e = sb_q.pop_front();
            check(e.name, rd, e.exp);
         end
         check($sformatf("vec%0d_gpio_o", i), 32'(gpio_o), 32'(vecs[i].exp_out));
         check($sformatf("vec%0d_dir", i), 32'(gpio_dir_o), 32'(vecs[i].exp_dir));
      end

      // Test 3: rise on pin 0 -> STAT after 3 edges, irq after 4, W1C clears
      @(negedge clock); gpio_i = 8'hA4;
      repeat (4) @(posedge clock);
      wr(4'd6, 32'h0000_0001);
      @(negedge clock); gpio_i = 8'hA5;
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("rise_irq_t3", {31'd0, irq_o}, 32'd0);
      @(posedge clock); #1;
      check("rise_irq_t4", {31'd0, irq_o}, 32'd1);
      read_expect("rise_stat", 4'd8, 32'h1);
      wr(4'd8, 32'h0000_0001);
      check("w1c_irq_low", {31'd0, irq_o}, 32'd0);
      read_expect("w1c_stat", 4'd8, 32'h0);

      // Test 4: W1C on the same edge as a new fall event keeps the bit
      @(negedge clock); gpio_i = 8'hA4;
      repeat (4) @(posedge clock);
      @(negedge clock); gpio_i = 8'hA5;
      repeat (5) @(posedge clock);
      #1;
      check("pre_race_irq", {31'd0, irq_o}, 32'd1);
      wr(4'd7, 32'h0000_0001);
      @(negedge clock); gpio_i = 8'hA4;
      repeat (2) @(posedge clock);
      wr(4'd8, 32'h0000_0001);
      check("race_irq", {31'd0, irq_o}, 32'd1);
      repeat (2) @(posedge clock);
      #1;
      check("race_irq_hold", {31'd0, irq_o}, 32'd1);
      read_expect("race_stat", 4'd8, 32'h1);
      wr(4'd8, 32'h0000_0001);
      check("race_clear_irq", {31'd0, irq_o}, 32'd0);

      // Test 5: pins high through reset must not report edges
      @(negedge clock); gpio_i = 8'hFF; reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst2_gpio_o", 32'(gpio_o), 32'h05);
      check("rst2_irq", {31'd0, irq_o}, 32'd0);
      @(negedge clock); reset_n = 1'b1;
      wr(4'd6, 32'h0000_00FF);
      wr(4'd7, 32'h0000_00FF);
      repeat (10) @(posedge clock);
      #1;
      check("arm_irq", {31'd0, irq_o}, 32'd0);
      read_expect("arm_stat", 4'd8, 32'h0);
      read_expect("arm_in", 4'd0, 32'h0000_00FF);

      // Test 6: reset during an access drops it without ack
      @(negedge clock);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 6'h00; wb_sel_i = 4'hF;
      #2 reset_n = 1'b0;
      @(posedge clock); #1;
      check("midrst_ack", {31'd0, wb_ack_o}, 32'd0);
      check("midrst_dat", wb_dat_o, 32'd0);
      @(negedge clock);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      #1 reset_n = 1'b1;
      @(posedge clock); #1;
      check("midrst_ack_after", {31'd0, wb_ack_o}, 32'd0);
      repeat (4) @(posedge clock);
      read_expect("post_rst_in", 4'd0, 32'h0000_00FF);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
